// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Multicycle sequencer between the control unit/datapath and a single-port
// synchronous memory. It takes one byte-addressed read or write request at a
// time, converts the byte address to a word index, drives the memory port, and
// captures read data into the instruction register (ir) or the memory data
// register (mdr).
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   req, we, ir_load  request strobe (sampled only while idle), write select,
//                     read destination (1 = ir, 0 = mdr)
//   byte_addr, wdata  byte address and write data of the request
//   busy, done, err   status: not idle / one-cycle completion / rejected request
//   ir, mdr           capture registers for read data
//   mem_r_wbar, mem_addr, mem_wdata, mem_rdata   memory port
//
// All outputs come straight from registers. The next value of every status
// output is derived from the next state, so it lines up with that state.
module mem_access_ctrl #(
    parameter int ADDR_SHIFT = 2,
    parameter int MEM_DEPTH  = 128,
    parameter int RD_WAIT    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        ir_load,
    input  logic [31:0] byte_addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic        mem_r_wbar,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_CAPTURE,
        S_DONE,
        S_ERR
    } state_t;

    // Low address bits that must be zero for an aligned access.
    localparam logic [31:0] ALIGN_MASK = (32'd1 << ADDR_SHIFT) - 32'd1;
    // Counter start value; WAIT lasts exactly RD_WAIT cycles (count-1 .. 0).
    localparam logic [3:0]  WAIT_LOAD  = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

    state_t      state_reg, state_next;
    logic        we_reg, we_next;
    logic        ir_load_reg, ir_load_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [31:0] ir_reg, ir_next;
    logic [31:0] mdr_reg, mdr_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        r_wbar_reg, r_wbar_next;

    logic [31:0] word_idx;
    logic        req_bad;

    assign word_idx = byte_addr >> ADDR_SHIFT;
    // Misaligned, beyond the memory, or a write that names ir as destination.
    assign req_bad  = ((byte_addr & ALIGN_MASK) != 32'd0)
                    || (word_idx >= 32'(MEM_DEPTH))
                    || (we && ir_load);

    always_comb begin
        state_next     = state_reg;
        we_next        = we_reg;
        ir_load_next   = ir_load_reg;
        wait_cnt_next  = wait_cnt_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        ir_next        = ir_reg;
        mdr_next       = mdr_reg;

        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    if (req_bad) begin
                        // Rejected: memory port left untouched.
                        state_next = S_ERR;
                    end else begin
                        state_next     = S_ACCESS;
                        mem_addr_next  = word_idx;
                        mem_wdata_next = wdata;
                        we_next        = we;
                        ir_load_next   = ir_load;
                    end
                end
            end
            S_ACCESS: begin
                if (we_reg) begin
                    state_next = S_DONE;
                end else if (RD_WAIT > 0) begin
                    state_next    = S_WAIT;
                    wait_cnt_next = WAIT_LOAD;
                end else begin
                    state_next = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = S_CAPTURE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            S_CAPTURE: begin
                if (ir_load_reg) begin
                    ir_next = mem_rdata;
                end else begin
                    mdr_next = mem_rdata;
                end
                state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs registered from the next state so they align with it.
    always_comb begin
        busy_next   = (state_next != S_IDLE);
        done_next   = (state_next == S_DONE) || (state_next == S_ERR);
        err_next    = (state_next == S_ERR);
        // Write strobe is only ever low in the ACCESS cycle of a write.
        r_wbar_next = !((state_next == S_ACCESS) && we_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            we_reg        <= 1'b0;
            ir_load_reg   <= 1'b0;
            wait_cnt_reg  <= 4'd0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            ir_reg        <= 32'd0;
            mdr_reg       <= 32'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            r_wbar_reg    <= 1'b1;
        end else begin
            state_reg     <= state_next;
            we_reg        <= we_next;
            ir_load_reg   <= ir_load_next;
            wait_cnt_reg  <= wait_cnt_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            ir_reg        <= ir_next;
            mdr_reg       <= mdr_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            r_wbar_reg    <= r_wbar_next;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign ir         = ir_reg;
    assign mdr        = mdr_reg;
    assign mem_r_wbar = r_wbar_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Two instances: u_dut0 (RD_WAIT=0) and u_dut3 (RD_WAIT=3), each with its own
// behavioural synchronous memory. Expected results are pushed to a scoreboard
// queue when a request is driven and popped when the DUT pulses done.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic mem_init = 1'b1;

    always #5 clk = ~clk;

    logic        req0 = 0, we0 = 0, il0 = 0;
    logic [31:0] addr0 = 0, wd0 = 0;
    logic        busy0, done0, err0, r_wbar0;
    logic [31:0] ir0, mdr0, maddr0, mwdata0;
    logic [31:0] mrdata0;

    logic        req3 = 0, we3 = 0, il3 = 0;
    logic [31:0] addr3 = 0, wd3 = 0;
    logic        busy3, done3, err3, r_wbar3;
    logic [31:0] ir3, mdr3, maddr3, mwdata3;
    logic [31:0] mrdata3;

    mem_access_ctrl #(.ADDR_SHIFT(2), .MEM_DEPTH(128), .RD_WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .ir_load(il0),
        .byte_addr(addr0), .wdata(wd0), .busy(busy0), .done(done0), .err(err0),
        .ir(ir0), .mdr(mdr0), .mem_r_wbar(r_wbar0), .mem_addr(maddr0),
        .mem_wdata(mwdata0), .mem_rdata(mrdata0)
    );

    mem_access_ctrl #(.ADDR_SHIFT(2), .MEM_DEPTH(128), .RD_WAIT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .ir_load(il3),
        .byte_addr(addr3), .wdata(wd3), .busy(busy3), .done(done3), .err(err3),
        .ir(ir3), .mdr(mdr3), .mem_r_wbar(r_wbar3), .mem_addr(maddr3),
        .mem_wdata(mwdata3), .mem_rdata(mrdata3)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h0022_1820 : (32'h1000_0000 + 32'(i) * 32'h0001_0203);
    endfunction

    // Memory models: write on the edge while r_wbar=0, registered read.
    logic [31:0] mem0 [128];
    logic [31:0] mem3 [128];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem0[i] <= init_word(i);
        end else if (!r_wbar0) begin
            mem0[maddr0[6:0]] <= mwdata0;
        end
        mrdata0 <= mem0[maddr0[6:0]];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem3[i] <= init_word(i);
        end else if (!r_wbar3) begin
            mem3[maddr3[6:0]] <= mwdata3;
        end
        mrdata3 <= mem3[maddr3[6:0]];
    end

    typedef struct {
        logic        err;
        int          lat;
        logic [31:0] addr;
        logic [31:0] ir;
        logic [31:0] mdr;
        int          wlow;
    } exp_t;

    typedef struct {
        logic        busy, done, err, r_wbar;
        logic [31:0] ir, mdr, addr, wdata;
    } obs_t;

    typedef struct {
        logic        we;
        logic        il;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] shadow [2][128];
    logic [31:0] exp_ir [2];
    logic [31:0] exp_mdr [2];
    int          errors = 0;
    int          checks = 0;

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.busy = busy0; o.done = done0; o.err = err0; o.r_wbar = r_wbar0;
            o.ir = ir0; o.mdr = mdr0; o.addr = maddr0; o.wdata = mwdata0;
        end else begin
            o.busy = busy3; o.done = done3; o.err = err3; o.r_wbar = r_wbar3;
            o.ir = ir3; o.mdr = mdr3; o.addr = maddr3; o.wdata = mwdata3;
        end
        return o;
    endfunction

    task automatic drive(input int sel, input logic r, input logic w, input logic il,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            req0 = r; we0 = w; il0 = il; addr0 = a; wd0 = d;
        end else begin
            req3 = r; we3 = w; il3 = il; addr3 = a; wd3 = d;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One request on instance sel. Called in an idle cycle. With poke set, req is
    // re-asserted with another address every cycle while the access is in flight.
    task automatic run_txn(input int sel, input logic w, input logic il,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic exp_err, input int exp_lat, input bit poke);
        exp_t e;
        exp_t got_e;
        obs_t o;
        int   idx;
        int   wlow;
        bit   got;
        idx = int'(a[8:2]);
        if (!exp_err) begin
            if (w)       shadow[sel][idx] = d;
            else if (il) exp_ir[sel]      = shadow[sel][idx];
            else         exp_mdr[sel]     = shadow[sel][idx];
        end
        e.err  = exp_err;
        e.lat  = exp_lat;
        e.addr = a >> 2;
        e.ir   = exp_ir[sel];
        e.mdr  = exp_mdr[sel];
        e.wlow = (!exp_err && w) ? 1 : 0;
        sb_q.push_back(e);

        drive(sel, 1'b1, w, il, a, d);
        @(posedge clk); #1;
        drive(sel, 1'b0, w, il, a, d);
        wlow = 0;
        got  = 0;
        for (int c = 1; c <= 30 && !got; c++) begin
            @(negedge clk);
            o = sample(sel);
            if (!o.r_wbar) begin
                wlow++;
                check("mem_wdata", o.wdata, d);
            end
            if (!exp_err) check("mem_addr_hold", o.addr, e.addr);
            if (o.done) begin
                got   = 1;
                got_e = sb_q.pop_front();
                check("latency", 32'(c), 32'(got_e.lat));
                check("err", {31'd0, o.err}, {31'd0, got_e.err});
                check("ir", o.ir, got_e.ir);
                check("mdr", o.mdr, got_e.mdr);
                check("wr_strobe_cycles", 32'(wlow), 32'(got_e.wlow));
            end
            if (poke) drive(sel, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, expected done within 30 cycles");
            sb_q.delete();
        end
        @(posedge clk); #1;
        if (poke) drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        o = sample(sel);
        check("done_one_cycle", {31'd0, o.done}, 32'd0);
        check("idle_after", {31'd0, o.busy}, 32'd0);
    endtask

    vec_t vecs [11];
    obs_t o;

    initial begin
        vecs[0]  = '{we: 0, il: 1, addr: 32'h0000_0000, wdata: 32'h0,         exp_err: 0, exp_lat: 3};
        vecs[1]  = '{we: 1, il: 0, addr: 32'h0000_0040, wdata: 32'hDEAD_BEEF, exp_err: 0, exp_lat: 2};
        vecs[2]  = '{we: 0, il: 0, addr: 32'h0000_0040, wdata: 32'h0,         exp_err: 0, exp_lat: 3};
        vecs[3]  = '{we: 0, il: 0, addr: 32'h0000_0006, wdata: 32'h0,         exp_err: 1, exp_lat: 1};
        vecs[4]  = '{we: 0, il: 1, addr: 32'h0000_0200, wdata: 32'h0,         exp_err: 1, exp_lat: 1};
        vecs[5]  = '{we: 1, il: 1, addr: 32'h0000_0010, wdata: 32'h5555_AAAA, exp_err: 1, exp_lat: 1};
        vecs[6]  = '{we: 1, il: 0, addr: 32'h0000_01FC, wdata: 32'hCAFE_F00D, exp_err: 0, exp_lat: 2};
        vecs[7]  = '{we: 0, il: 1, addr: 32'h0000_01FC, wdata: 32'h0,         exp_err: 0, exp_lat: 3};
        vecs[8]  = '{we: 1, il: 0, addr: 32'h0000_0001, wdata: 32'h1111_2222, exp_err: 1, exp_lat: 1};
        vecs[9]  = '{we: 0, il: 0, addr: 32'h0000_0004, wdata: 32'h0,         exp_err: 0, exp_lat: 3};
        vecs[10] = '{we: 0, il: 0, addr: 32'hFFFF_FFFC, wdata: 32'h0,         exp_err: 1, exp_lat: 1};

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 128; i++) shadow[s][i] = init_word(i);
            exp_ir[s]  = 32'h0;
            exp_mdr[s] = 32'h0;
        end

        // Asynchronous reset applied while the clock is low, checked before any edge.
        #2 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            o = sample(s);
            check("rst_r_wbar", {31'd0, o.r_wbar}, 32'd1);
            check("rst_busy", {31'd0, o.busy}, 32'd0);
            check("rst_done", {31'd0, o.done}, 32'd0);
            check("rst_err", {31'd0, o.err}, 32'd0);
            check("rst_ir", o.ir, 32'd0);
            check("rst_mdr", o.mdr, 32'd0);
            check("rst_mem_addr", o.addr, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven accesses on the RD_WAIT=0 instance.
        for (int i = 0; i < 11; i++) begin
            run_txn(0, vecs[i].we, vecs[i].il, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_err, vecs[i].exp_lat, 1'b0);
            $display("vec %0d: we=%0b il=%0b addr=%h err=%0b lat=%0d", i, vecs[i].we,
                     vecs[i].il, vecs[i].addr, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // RD_WAIT=3: write, then a read with req poked every busy cycle.
        run_txn(1, 1'b1, 1'b0, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 2, 1'b0);
        $display("dut3 write addr=00000020 lat=2");
        run_txn(1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 6, 1'b1);
        $display("dut3 read with busy pokes addr=00000020 lat=6");
        run_txn(1, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 1'b0, 6, 1'b0);
        $display("dut3 read to ir addr=00000000 lat=6");
        run_txn(1, 1'b0, 1'b1, 32'h0000_0202, 32'h0, 1'b1, 1, 1'b1);
        $display("dut3 error with busy pokes addr=00000202 lat=1");

        // Reset during the ACCESS cycle of a write: nothing is committed.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h1234_5678);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        o = sample(0);
        check("wr_access_strobe", {31'd0, o.r_wbar}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        o = sample(0);
        check("abort_r_wbar", {31'd0, o.r_wbar}, 32'd1);
        check("abort_busy", {31'd0, o.busy}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            exp_ir[s]  = 32'h0;
            exp_mdr[s] = 32'h0;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            o = sample(0);
            check("abort_no_done", {31'd0, o.done}, 32'd0);
        end
        $display("reset mid-write addr=00000080");
        run_txn(0, 1'b0, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 3, 1'b0);
        $display("readback after aborted write addr=00000080");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
